// File: rtl/bp_be_prefetch_issuer_pkg.sv
// Shared types for the prefetch issuer: FSM states, dispatch packet layout and config lookup.
// Optional duplicate-line suppression is enabled by BP_BE_PREFETCH_DEDUP_EN.
package bp_be_prefetch_issuer_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int vaddr_width_gp        = 39;
  localparam int dcache_block_width_gp = 512;
  localparam int dword_width_gp        = 64;
  localparam int line_offset_width_gp  = $clog2(dcache_block_width_gp / 8);

  typedef enum logic [0:0] {e_idle = 1'b0, e_issue = 1'b1} bp_be_pref_state_e;

  typedef enum logic [3:0] {
    e_dcache_op_lb = 4'd0,
    e_dcache_op_lh = 4'd1,
    e_dcache_op_lw = 4'd2,
    e_dcache_op_ld = 4'd3,
    e_dcache_op_sd = 4'd7
  } bp_be_dcache_fu_op_e;

  typedef struct packed {
    logic pipe_int_v, pipe_mem_early_v, pipe_mem_final_v;
    logic irf_w_v, frf_w_v, dcache_r_v, dcache_w_v;
    bp_be_dcache_fu_op_e fu_op;
  } bp_be_decode_s;

  typedef struct packed {
    logic illegal_instr, instr_page_fault, itlb_miss;
  } bp_be_exception_s;

  typedef struct packed {
    logic dbreak, fencei_clean;
  } bp_be_special_s;

  typedef struct packed {
    logic v, queue_v, instr_v, nspec_v;
    logic [vaddr_width_gp-1:0] pc;
    logic [dword_width_gp-1:0] rs1, rs2, imm;
    bp_be_decode_s    decode;
    bp_be_exception_s exception;
    bp_be_special_s   special;
  } bp_be_dispatch_pkt_s;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_pref_addr_gen.sv
// Prefetch address accumulator: computes the distance-ahead base, steps by the stride and,
// when BP_BE_PREFETCH_DEDUP_EN is defined, flags addresses that fall in the last issued line.
module bp_be_pref_addr_gen
  import bp_be_prefetch_issuer_pkg::*;
  #(parameter int vaddr_width_p  = 39
   ,parameter int stride_width_p = 8
   ,parameter int distance_p     = 4
   )
  (input  logic                      clk_i
  ,input  logic                      reset_i
  ,input  logic                      flush_i
  ,input  logic                      load_i
  ,input  logic [vaddr_width_p-1:0]  eff_addr_i
  ,input  logic [stride_width_p-1:0] stride_i
  ,input  logic                      advance_i
  ,input  logic                      mark_i
  ,output logic [vaddr_width_p-1:0]  cur_addr_o
  ,output logic                      line_hit_o
  );

  logic [vaddr_width_p-1:0] stride_ext_s, base_s, cur_r, stride_r;

  assign stride_ext_s = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
  // Arithmetic is modulo 2^vaddr_width_p, so negative strides and wrap need no special case
  assign base_s       = eff_addr_i + stride_ext_s * vaddr_width_p'(distance_p);
  assign cur_addr_o   = cur_r;

  // Current address and latched stride
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cur_r    <= '0;
      stride_r <= '0;
    end else if (load_i) begin
      cur_r    <= base_s;
      stride_r <= stride_ext_s;
    end else if (advance_i) begin
      cur_r    <= cur_r + stride_r;
      stride_r <= stride_r;
    end else begin
      cur_r    <= cur_r;
      stride_r <= stride_r;
    end
  end

`ifdef BP_BE_PREFETCH_DEDUP_EN
  localparam int line_width_lp = vaddr_width_p - line_offset_width_gp;

  logic [line_width_lp-1:0] last_line_r;
  logic                     line_v_r;

  // Last issued cache line; a new descriptor or a flush forgets it
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_line_r <= '0;
      line_v_r    <= 1'b0;
    end else if (load_i | flush_i) begin
      last_line_r <= '0;
      line_v_r    <= 1'b0;
    end else if (mark_i) begin
      last_line_r <= cur_r[vaddr_width_p-1:line_offset_width_gp];
      line_v_r    <= 1'b1;
    end else begin
      last_line_r <= last_line_r;
      line_v_r    <= line_v_r;
    end
  end

  assign line_hit_o = line_v_r & (cur_r[vaddr_width_p-1:line_offset_width_gp] == last_line_r);
`else
  logic unused_dedup_s;
  assign unused_dedup_s = mark_i ^ flush_i;
  assign line_hit_o     = 1'b0;
`endif

endmodule

// File: rtl/bp_be_prefetch_issuer.sv
// Turns loop descriptors into a stream of non-speculative prefetch dispatch packets issued
// in idle dispatch slots. BP_BE_PREFETCH_DEDUP_EN suppresses repeat packets to the same line.
module bp_be_prefetch_issuer
  import bp_be_prefetch_issuer_pkg::*;
  #(parameter bp_params_e bp_params_p    = e_bp_default_cfg
   ,parameter int         loop_range_p   = 8
   ,parameter int         stride_width_p = 8
   ,parameter int         distance_p     = 4
   ,parameter int         max_pref_p     = 8
   ,localparam int        vaddr_width_p         = bp_vaddr_width(bp_params_p)
   ,localparam int        dispatch_pkt_width_lp = $bits(bp_be_dispatch_pkt_s)
   )
  (input  logic                             clk_i
  ,input  logic                             reset_i
  ,input  logic                             flush_i
  ,input  logic [vaddr_width_p-1:0]         pc_i
  ,input  logic [loop_range_p-1:0]          loop_counter_i
  ,input  logic [vaddr_width_p-1:0]         eff_addr_i
  ,input  logic [stride_width_p-1:0]        stride_i
  ,input  logic                             v_i
  ,output logic                             ready_and_o
  ,output logic                             v_o
  ,output logic [dispatch_pkt_width_lp-1:0] dispatch_pkt_o
  ,input  logic                             yumi_i
  ,output logic                             busy_o
  );

  localparam int count_width_lp = $clog2(max_pref_p + 1);

  bp_be_pref_state_e          state_r, state_n_s;
  logic [count_width_lp-1:0]  count_r, count_init_s;
  logic [vaddr_width_p-1:0]   pc_r, cur_addr_s;
  logic                       accept_s, line_hit_s, skip_s, issue_s, advance_s;
  bp_be_dispatch_pkt_s        pkt_s;

  assign count_init_s = (loop_counter_i > loop_range_p'(max_pref_p))
                        ? count_width_lp'(max_pref_p)
                        : count_width_lp'(loop_counter_i);
  assign accept_s  = v_i & ready_and_o & ~flush_i;
  assign skip_s    = (state_r == e_issue) & line_hit_s;
  assign issue_s   = v_o & yumi_i;
  assign advance_s = (state_r == e_issue) & (issue_s | skip_s);

  bp_be_pref_addr_gen
   #(.vaddr_width_p(vaddr_width_p)
    ,.stride_width_p(stride_width_p)
    ,.distance_p(distance_p)
    )
   addr_gen
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.flush_i(flush_i)
    ,.load_i(accept_s)
    ,.eff_addr_i(eff_addr_i)
    ,.stride_i(stride_i)
    ,.advance_i(advance_s)
    ,.mark_i(issue_s)
    ,.cur_addr_o(cur_addr_s)
    ,.line_hit_o(line_hit_s)
    );

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n_s;
  end

  // FSM next state; flush overrides everything
  always_comb begin
    state_n_s = state_r;
    if (flush_i) begin
      state_n_s = e_idle;
    end else begin
      case (state_r)
        e_idle:  state_n_s = (accept_s && (count_init_s != '0)) ? e_issue : e_idle;
        e_issue: state_n_s = (advance_s && (count_r == count_width_lp'(1))) ? e_idle : e_issue;
        default: state_n_s = e_idle;
      endcase
    end
  end

  // Remaining prefetch budget
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)        count_r <= '0;
    else if (flush_i)   count_r <= '0;
    else if (accept_s)  count_r <= count_init_s;
    else if (advance_s) count_r <= count_r - count_width_lp'(1);
    else                count_r <= count_r;
  end

  // Descriptor pc captured for the whole stream
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       pc_r <= '0;
    else if (accept_s) pc_r <= pc_i;
    else               pc_r <= pc_r;
  end

  // FSM outputs and packet formation, driven only from registered state
  always_comb begin
    ready_and_o = 1'b0;
    v_o         = 1'b0;
    busy_o      = 1'b0;
    case (state_r)
      e_idle:  ready_and_o = ~reset_i;
      e_issue: begin
        v_o    = ~line_hit_s;
        busy_o = 1'b1;
      end
      default: ready_and_o = 1'b0;
    endcase

    pkt_s                         = '0;
    pkt_s.v                       = v_o;
    pkt_s.nspec_v                 = v_o;
    pkt_s.pc                      = pc_r;
    pkt_s.rs1                     = dword_width_gp'(cur_addr_s);
    pkt_s.decode.pipe_mem_early_v = 1'b1;
    pkt_s.decode.dcache_r_v       = 1'b1;
    pkt_s.decode.fu_op            = e_dcache_op_ld;
  end

  assign dispatch_pkt_o = pkt_s;

endmodule

// File: tb/tb_bp_be_prefetch_issuer.sv
// Self-checking bench for bp_be_prefetch_issuer; expected streams come from an arithmetic
// model of the descriptor rules (optionally with same-line suppression under BP_BE_PREFETCH_DEDUP_EN).
module tb_bp_be_prefetch_issuer;
  import bp_be_prefetch_issuer_pkg::*;

  localparam longint unsigned ADDR_MASK = (64'd1 << 39) - 64'd1;

  logic        clk = 1'b0;
  logic        reset, flush_i, v_i, yumi_i;
  logic [38:0] pc_i, eff_addr_i;
  logic [7:0]  loop_counter_i, stride_i;
  logic        ready_and_o, v_o, busy_o;
  logic [$bits(bp_be_dispatch_pkt_s)-1:0] pkt_raw;
  bp_be_dispatch_pkt_s pkt;

  int tests_run = 0;
  int tests_failed = 0;
  longint unsigned exp_q[$];

  assign pkt = bp_be_dispatch_pkt_s'(pkt_raw);

  bp_be_prefetch_issuer dut
    (.clk_i(clk), .reset_i(reset), .flush_i(flush_i), .pc_i(pc_i)
    ,.loop_counter_i(loop_counter_i), .eff_addr_i(eff_addr_i), .stride_i(stride_i)
    ,.v_i(v_i), .ready_and_o(ready_and_o), .v_o(v_o), .dispatch_pkt_o(pkt_raw)
    ,.yumi_i(yumi_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected address list: addr_k = eff + stride*(distance+k), at most 8 of them
  task automatic model_stream(input longint unsigned eff, input int stride, input int cnt);
    int n;
    longint unsigned a;
`ifdef BP_BE_PREFETCH_DEDUP_EN
    longint unsigned line, last_line;
    bit have_line;
    have_line = 1'b0;
    last_line = 64'd0;
`endif
    exp_q.delete();
    n = (cnt > 8) ? 8 : cnt;
    for (int k = 0; k < n; k++) begin
      a = (eff + 64'(longint'(stride) * longint'(4 + k))) & ADDR_MASK;
`ifdef BP_BE_PREFETCH_DEDUP_EN
      line = a >> 6;
      if (have_line && line == last_line) continue;
      have_line = 1'b1;
      last_line = line;
`endif
      exp_q.push_back(a);
    end
  endtask

  function automatic bp_be_dispatch_pkt_s exp_pkt(input longint unsigned a, input logic [38:0] p);
    bp_be_dispatch_pkt_s e;
    e = '0;
    e.v = 1'b1;
    e.nspec_v = 1'b1;
    e.pc = p;
    e.rs1 = a;
    e.decode.pipe_mem_early_v = 1'b1;
    e.decode.dcache_r_v = 1'b1;
    e.decode.fu_op = e_dcache_op_ld;
    return e;
  endfunction

  task automatic send_desc(input logic [38:0] p, input longint unsigned eff, input int stride, input int cnt);
    pc_i = p;
    eff_addr_i = 39'(eff);
    stride_i = 8'(stride);
    loop_counter_i = 8'(cnt);
    v_i = 1'b1;
    tests_run++;
    if (ready_and_o !== 1'b1 || v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL desc_accept: ready=%b v_o=%b, want ready=1 v_o=0", ready_and_o, v_o);
    end
    step();
    v_i = 1'b0;
  endtask

  // Drain a stream, comparing each consumed packet and checking stalled packets hold still
  task automatic collect(input int start_idx, input int yumi_pct, input logic [38:0] p, input int budget);
    int idx, cyc;
    bit held;
    bp_be_dispatch_pkt_s prev;
    idx = start_idx; cyc = 0; held = 1'b0; prev = '0;
    while (busy_o === 1'b1 && cyc < budget) begin
      if (held && v_o === 1'b1) begin
        tests_run++;
        if (pkt !== prev) begin
          tests_failed++;
          $display("FAIL hold_stable: rs1=%h want %h", pkt.rs1, prev.rs1);
        end
      end
      held = 1'b0;
      if (v_o === 1'b1) begin
        yumi_i = (int'($urandom_range(0, 99)) < yumi_pct);
        if (yumi_i) begin
          tests_run++;
          if (idx >= exp_q.size()) begin
            tests_failed++;
            $display("FAIL extra_pkt: rs1=%h, want no packet", pkt.rs1);
          end else if (pkt !== exp_pkt(exp_q[idx], p)) begin
            tests_failed++;
            $display("FAIL pkt[%0d]: rs1=%h pc=%h, want rs1=%h pc=%h", idx, pkt.rs1, pkt.pc, exp_q[idx], p);
          end
          idx++;
        end else begin
          held = 1'b1;
          prev = pkt;
        end
      end else begin
        yumi_i = 1'b0;
      end
      step();
      cyc++;
    end
    yumi_i = 1'b0;
    if (cyc >= budget) begin
      tests_failed++;
      $display("FAIL timeout: busy_o=%b after %0d cycles, want 0", busy_o, cyc);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
    end
    tests_run++;
    if (idx != exp_q.size()) begin
      tests_failed++;
      $display("FAIL pkt_count: got %0d, want %0d", idx, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    pc_i = '0; eff_addr_i = '0; stride_i = '0; loop_counter_i = '0;
    #1;
    tests_run++;
    if (ready_and_o !== 1'b0 || v_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: ready=%b v_o=%b busy=%b, want 0 0 0", ready_and_o, v_o, busy_o);
    end
    step(); step();
    reset = 1'b0;
    #1;
    tests_run++;
    if (ready_and_o !== 1'b1 || v_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b v_o=%b busy=%b, want 1 0 0", ready_and_o, v_o, busy_o);
    end
  endtask

  task automatic test_basic();
    model_stream(64'h1000, 8, 3);
    send_desc(39'h0080000040, 64'h1000, 8, 3);
    tests_run++;
    if (v_o !== 1'b1 || ready_and_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency: v_o=%b ready=%b one cycle after accept, want 1 0", v_o, ready_and_o);
    end
    collect(0, 100, 39'h0080000040, 40);
    tests_run++;
    if (ready_and_o !== 1'b1 || v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_idle: ready=%b v_o=%b, want 1 0", ready_and_o, v_o);
    end
  endtask

  task automatic test_negative_cap();
    model_stream(64'h2000, -16, 20);
    send_desc(39'h0000001234, 64'h2000, -16, 20);
    collect(0, 100, 39'h0000001234, 60);
  endtask

  task automatic test_stall();
    bp_be_dispatch_pkt_s ref_pkt;
    model_stream(64'h4000, 64, 6);
    send_desc(39'h0000005550, 64'h4000, 64, 6);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (v_o !== 1'b1 || pkt !== exp_pkt(exp_q[i], 39'h0000005550)) begin
        tests_failed++;
        $display("FAIL stall_pre[%0d]: v_o=%b rs1=%h, want 1 %h", i, v_o, pkt.rs1, exp_q[i]);
      end
      yumi_i = 1'b1;
      step();
    end
    yumi_i = 1'b0;
    ref_pkt = exp_pkt(exp_q[2], 39'h0000005550);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (v_o !== 1'b1 || pkt !== ref_pkt) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: v_o=%b rs1=%h, want 1 %h", i, v_o, pkt.rs1, ref_pkt.rs1);
      end
      step();
    end
    collect(2, 100, 39'h0000005550, 40);
  endtask

  task automatic test_flush();
    int seen;
    model_stream(64'h3000, 64, 5);
    send_desc(39'h0000007770, 64'h3000, 64, 5);
    yumi_i = 1'b1;
    step();
    tests_run++;
    if (v_o !== 1'b1 || pkt !== exp_pkt(exp_q[1], 39'h0000007770)) begin
      tests_failed++;
      $display("FAIL flush_second: v_o=%b rs1=%h, want 1 %h", v_o, pkt.rs1, exp_q[1]);
    end
    flush_i = 1'b1;
    v_i = 1'b1;
    step();
    flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    tests_run++;
    if (v_o !== 1'b0 || ready_and_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_abort: v_o=%b ready=%b busy=%b, want 0 1 0", v_o, ready_and_o, busy_o);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (v_o === 1'b1) seen++;
      step();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL flush_quiet: v_o high %0d cycles, want 0", seen);
    end
  endtask

  task automatic test_zero_count();
    int seen;
    send_desc(39'h0000000abc, 64'h5000, 8, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (v_o === 1'b1 || ready_and_o !== 1'b1) seen++;
      step();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL zero_count: %0d bad cycles (v_o high or ready low), want 0", seen);
    end
  endtask

  task automatic test_dedup_pattern();
    model_stream(64'h0, 8, 8);
    send_desc(39'h0000000100, 64'h0, 8, 8);
    collect(0, 100, 39'h0000000100, 40);
  endtask

  task automatic test_random();
    longint unsigned eff;
    logic [7:0] sr;
    logic [38:0] p;
    int stride, cnt;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) eff = ADDR_MASK - 64'($urandom_range(0, 300));
      else eff = {32'($urandom), 32'($urandom)} & ADDR_MASK;
      sr = 8'($urandom);
      stride = int'($signed(sr));
      cnt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(9, 255)) : int'($urandom_range(0, 9));
      p = 39'({32'($urandom), 32'($urandom)});
      model_stream(eff, stride, cnt);
      send_desc(p, eff, stride, cnt);
      collect(0, 60, p, 200);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_cap();
    test_stall();
    test_flush();
    test_zero_count();
    test_dedup_pattern();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
